// File: rtl/spi_flash_pkg.sv
// Shared opcodes and controller state encoding for the SPI flash responder and its bench.
package spi_flash_pkg;

    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_PP_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    // WIP is never set: programming completes within one clk of the byte arriving.
    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_flash_array.sv
// Single-port byte array with 1-clk synchronous read; contents survive reset.
module spi_flash_array #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem_q [0:(1 << ADDR_BITS) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI (mode 0) flash responder: READ, PAGE PROGRAM, WREN/WRDI and RDSR over an
// oversampled SPI link, backed by a single-port byte array.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int MEM_ADDR_BITS = 12,
    parameter int PAGE_BITS     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_SPI_CLK,
    input  logic                     i_SPI_MOSI,
    input  logic                     i_SPI_CS,
    output logic                     o_SPI_MISO,
    output logic                     o_MISO_OE,
    output logic                     o_WEL,
    output logic                     o_prog_strobe,
    output logic [MEM_ADDR_BITS-1:0] o_prog_addr,
    output logic [7:0]               o_prog_data,
    output logic                     o_cmd_err
);

    localparam logic [MEM_ADDR_BITS-1:0] ADDR_ONE = MEM_ADDR_BITS'(1);
    localparam logic [PAGE_BITS-1:0]     PAGE_ONE = PAGE_BITS'(1);

    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t                     state_q, state_d;
    logic [4:0]                 bit_cnt_q, bit_cnt_d;
    logic [23:0]                rx_q, rx_d;
    logic [MEM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic                       is_prog_q, is_prog_d;
    logic [7:0]                 tx_q, tx_d;
    logic [2:0]                 tx_cnt_q, tx_cnt_d;
    logic                       fetch_q, fetch_d;
    logic                       load_q, load_d;
    logic                       miso_q, miso_d;
    logic                       oe_q, oe_d;
    logic                       wel_q, wel_d;
    logic                       err_q, err_d;
    logic                       strobe_q, strobe_d;
    logic [MEM_ADDR_BITS-1:0]   prog_addr_q, prog_addr_d;
    logic [7:0]                 prog_data_q, prog_data_d;

    logic                       sck_rise, sck_fall, cs_rise, cs_fall;
    logic [23:0]                rx_shift;
    logic [MEM_ADDR_BITS-1:0]   arr_addr;
    logic [7:0]                 arr_rdata;

    // Sync flops reset low, so a CS already low at reset release never shows a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            cs_prev_q   <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            sck_meta_q  <= i_SPI_CLK;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            cs_meta_q   <= i_SPI_CS;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= i_SPI_MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q & sck_prev_q;
    assign cs_rise  = cs_sync_q & ~cs_prev_q;
    assign cs_fall  = ~cs_sync_q & cs_prev_q;
    assign rx_shift = {rx_q[22:0], mosi_sync_q};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        is_prog_d   = is_prog_q;
        tx_d        = tx_q;
        tx_cnt_d    = tx_cnt_q;
        fetch_d     = 1'b0;
        load_d      = fetch_q;
        miso_d      = miso_q;
        oe_d        = oe_q;
        wel_d       = wel_q;
        err_d       = err_q;
        strobe_d    = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;

        if (load_q) begin
            tx_d = arr_rdata;
        end

        if (cs_rise) begin
            // CS rise wins over any SCK edge seen in the same clk.
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
            if (state_q == ST_PP_DATA || (state_q == ST_ADDR && is_prog_q)) begin
                wel_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            state_d   = ST_IGNORE;
                            case (rx_shift[7:0])
                                OP_READ: begin
                                    state_d   = ST_ADDR;
                                    is_prog_d = 1'b0;
                                end
                                OP_PP: begin
                                    if (wel_q) begin
                                        state_d   = ST_ADDR;
                                        is_prog_d = 1'b1;
                                    end else begin
                                        err_d = 1'b1;
                                    end
                                end
                                OP_WREN: wel_d = 1'b1;
                                OP_WRDI: wel_d = 1'b0;
                                OP_RDSR: begin
                                    state_d  = ST_STATUS;
                                    tx_d     = status_byte(wel_q);
                                    tx_cnt_d = '0;
                                end
                                default: err_d = 1'b1;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            addr_d    = rx_shift[MEM_ADDR_BITS-1:0];
                            tx_cnt_d  = '0;
                            if (is_prog_q) begin
                                state_d = ST_PP_DATA;
                            end else begin
                                state_d = ST_RD_DATA;
                                fetch_d = 1'b1;
                            end
                        end
                    end
                end
                ST_RD_DATA, ST_STATUS: begin
                    if (sck_fall) begin
                        miso_d   = tx_q[7];
                        oe_d     = 1'b1;
                        tx_d     = {tx_q[6:0], 1'b0};
                        tx_cnt_d = tx_cnt_q + 3'd1;
                        if (tx_cnt_q == 3'd7) begin
                            if (state_q == ST_RD_DATA) begin
                                addr_d  = addr_q + ADDR_ONE;
                                fetch_d = 1'b1;
                            end else begin
                                tx_d = status_byte(wel_q);
                            end
                        end
                    end
                end
                ST_PP_DATA: begin
                    if (sck_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = '0;
                            strobe_d    = 1'b1;
                            prog_addr_d = addr_q;
                            prog_data_d = rx_shift[7:0];
                            addr_d      = {addr_q[MEM_ADDR_BITS-1:PAGE_BITS],
                                           addr_q[PAGE_BITS-1:0] + PAGE_ONE};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            addr_q      <= '0;
            is_prog_q   <= 1'b0;
            tx_q        <= '0;
            tx_cnt_q    <= '0;
            fetch_q     <= 1'b0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            wel_q       <= 1'b0;
            err_q       <= 1'b0;
            strobe_q    <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            is_prog_q   <= is_prog_d;
            tx_q        <= tx_d;
            tx_cnt_q    <= tx_cnt_d;
            fetch_q     <= fetch_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            wel_q       <= wel_d;
            err_q       <= err_d;
            strobe_q    <= strobe_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
        end
    end

    // The write port uses the registered commit so the strobe and the array update coincide.
    assign arr_addr = strobe_q ? prog_addr_q : addr_q;

    spi_flash_array #(
        .ADDR_BITS(MEM_ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .we   (strobe_q),
        .addr (arr_addr),
        .wdata(prog_data_q),
        .rdata(arr_rdata)
    );

    assign o_SPI_MISO    = miso_q;
    assign o_MISO_OE     = oe_q;
    assign o_WEL         = wel_q;
    assign o_prog_strobe = strobe_q;
    assign o_prog_addr   = prog_addr_q;
    assign o_prog_data   = prog_data_q;
    assign o_cmd_err     = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised SPI master driving the responder against a transaction-level flash model.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        cs = 1'b1;
    logic        o_SPI_MISO, o_MISO_OE, o_WEL, o_prog_strobe, o_cmd_err;
    logic [11:0] o_prog_addr;
    logic [7:0]  o_prog_data;

    spi_flash_responder #(
        .MEM_ADDR_BITS(12),
        .PAGE_BITS    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_SPI_CLK    (sck),
        .i_SPI_MOSI   (mosi),
        .i_SPI_CS     (cs),
        .o_SPI_MISO   (o_SPI_MISO),
        .o_MISO_OE    (o_MISO_OE),
        .o_WEL        (o_WEL),
        .o_prog_strobe(o_prog_strobe),
        .o_prog_addr  (o_prog_addr),
        .o_prog_data  (o_prog_data),
        .o_cmd_err    (o_cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [7:0]  mem_m [4096];
    bit          mem_v [4096];
    bit          wel_m = 1'b0;
    bit          err_m = 1'b0;
    bit          quiet = 1'b0;
    wr_t         exp_q[$];
    wr_t         strobe_log[$];
    logic [7:0]  rd_buf [8];
    logic [7:0]  wr_buf [8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Compare process: every committed byte against the model, idle outputs while the bus is quiet.
    always @(negedge clk) begin
        wr_t e;
        if (!reset) begin
            if (o_prog_strobe) begin
                e.a = o_prog_addr;
                e.d = o_prog_data;
                strobe_log.push_back(e);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h expected none", o_prog_addr, o_prog_data);
                end else begin
                    e = exp_q.pop_front();
                    check("prog_addr", 32'(o_prog_addr), 32'(e.a));
                    check("prog_data", 32'(o_prog_data), 32'(e.d));
                end
            end
            if (quiet) begin
                check("idle_wel", 32'(o_WEL), 32'(wel_m));
                check("idle_err", 32'(o_cmd_err), 32'(err_m));
                check("idle_oe", 32'(o_MISO_OE), 32'd0);
                check("idle_miso", 32'(o_SPI_MISO), 32'd0);
            end
        end
    end

    task automatic half();
        repeat ($urandom_range(4, 6)) @(negedge clk);
    endtask

    task automatic gap();
        repeat (6) @(negedge clk);
        quiet = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_low();
        quiet = 1'b0;
        cs = 1'b0;
        half();
    endtask

    task automatic cs_high();
        half();
        cs = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] exp, input bit chk, input bit exp_oe,
                        output logic [7:0] rx);
        logic [7:0] r;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            half();
            r[i] = o_SPI_MISO;
            check("miso_oe", 32'(o_MISO_OE), 32'(exp_oe));
            if (!exp_oe) check("miso_idle", 32'(o_SPI_MISO), 32'd0);
            sck = 1'b1;
            half();
            sck = 1'b0;
        end
        if (chk) check("miso_byte", 32'(r), 32'(exp));
        rx = r;
    endtask

    task automatic send_addr(input logic [23:0] addr);
        logic [7:0] d;
        for (int k = 2; k >= 0; k--) xfer(addr[k*8 +: 8], 8'h00, 1'b0, 1'b0, d);
    endtask

    task automatic t_simple(input logic [7:0] op);
        logic [7:0] d;
        cs_low();
        xfer(op, 8'h00, 1'b0, 1'b0, d);
        if (op == OP_WREN) wel_m = 1'b1;
        else if (op == OP_WRDI) wel_m = 1'b0;
        else begin
            err_m = 1'b1;
            xfer(8'($urandom), 8'h00, 1'b0, 1'b0, d);
        end
        cs_high();
        gap();
    endtask

    task automatic t_status(input int n);
        logic [7:0] d;
        cs_low();
        xfer(OP_RDSR, 8'h00, 1'b0, 1'b0, d);
        for (int i = 0; i < n; i++) xfer(8'($urandom), {6'b0, wel_m, 1'b0}, 1'b1, 1'b1, rd_buf[i]);
        cs_high();
        gap();
    endtask

    task automatic t_read(input logic [23:0] addr, input int n);
        logic [11:0] a;
        logic [7:0]  d;
        a = addr[11:0];
        cs_low();
        xfer(OP_READ, 8'h00, 1'b0, 1'b0, d);
        send_addr(addr);
        for (int i = 0; i < n; i++) begin
            xfer(8'($urandom), mem_m[a], mem_v[a], 1'b1, rd_buf[i]);
            a = a + 12'd1;
        end
        cs_high();
        gap();
    endtask

    task automatic t_prog(input logic [23:0] addr, input int n);
        logic [11:0] a;
        logic [7:0]  d;
        bit          en;
        wr_t         e;
        en = wel_m;
        a = addr[11:0];
        cs_low();
        xfer(OP_PP, 8'h00, 1'b0, 1'b0, d);
        if (!en) err_m = 1'b1;
        send_addr(addr);
        for (int i = 0; i < n; i++) begin
            if (en) begin
                e.a = a;
                e.d = wr_buf[i];
                exp_q.push_back(e);
                mem_m[a] = wr_buf[i];
                mem_v[a] = 1'b1;
                a = {a[11:8], a[7:0] + 8'd1};
            end
            xfer(wr_buf[i], 8'h00, 1'b0, 1'b0, d);
        end
        cs_high();
        wel_m = 1'b0;
        gap();
        check("pp_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        quiet = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wel_m = 1'b0;
        err_m = 1'b0;
        exp_q.delete();
        gap();
    endtask

    task automatic check_reset_outputs();
        check("rst_miso", 32'(o_SPI_MISO), 32'd0);
        check("rst_oe", 32'(o_MISO_OE), 32'd0);
        check("rst_wel", 32'(o_WEL), 32'd0);
        check("rst_strobe", 32'(o_prog_strobe), 32'd0);
        check("rst_err", 32'(o_cmd_err), 32'd0);
        check("rst_prog_addr", 32'(o_prog_addr), 32'd0);
        check("rst_prog_data", 32'(o_prog_data), 32'd0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  d;
        logic [7:0]  op;
        logic [11:0] a12;
        logic [23:0] addr24;
        int unsigned kind;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        gap();

        // Write-enable then a single-byte program.
        t_simple(OP_WREN);
        check("wel_after_wren", 32'(o_WEL), 32'd1);
        wr_buf[0] = 8'hA5;
        strobe_log.delete();
        t_prog(24'h000123, 1);
        check("pp1_count", 32'(strobe_log.size()), 32'd1);
        if (strobe_log.size() >= 1) begin
            check("pp1_addr", 32'(strobe_log[0].a), 32'h123);
            check("pp1_data", 32'(strobe_log[0].d), 32'hA5);
        end
        check("wel_after_pp", 32'(o_WEL), 32'd0);

        t_read(24'h000123, 1);
        check("rd_a5", 32'(rd_buf[0]), 32'hA5);

        // Read wrapping past the top of the array.
        t_simple(OP_WREN);
        wr_buf[0] = 8'h11;
        wr_buf[1] = 8'h22;
        t_prog(24'h000FFE, 2);
        t_simple(OP_WREN);
        wr_buf[0] = 8'h33;
        t_prog(24'h000000, 1);
        t_read(24'hFFFFFE, 3);
        check("wrap_b0", 32'(rd_buf[0]), 32'h11);
        check("wrap_b1", 32'(rd_buf[1]), 32'h22);
        check("wrap_b2", 32'(rd_buf[2]), 32'h33);

        // Status with WEL set, then page wrap during program, then status again.
        t_simple(OP_WREN);
        t_status(2);
        check("status_wel_b0", 32'(rd_buf[0]), 32'h02);
        check("status_wel_b1", 32'(rd_buf[1]), 32'h02);
        wr_buf[0] = 8'h5A;
        wr_buf[1] = 8'hC3;
        strobe_log.delete();
        t_prog(24'h0001FF, 2);
        check("page_count", 32'(strobe_log.size()), 32'd2);
        if (strobe_log.size() >= 2) begin
            check("page_addr0", 32'(strobe_log[0].a), 32'h1FF);
            check("page_addr1", 32'(strobe_log[1].a), 32'h100);
        end
        t_status(1);
        check("status_after_pp", 32'(rd_buf[0]), 32'h00);

        // Program without WEL leaves the array untouched.
        t_simple(OP_WREN);
        wr_buf[0] = 8'h3C;
        t_prog(24'h000200, 1);
        wr_buf[0] = 8'h77;
        t_prog(24'h000200, 1);
        check("err_pp_no_wel", 32'(o_cmd_err), 32'd1);
        t_read(24'h000200, 1);
        check("unchanged_200", 32'(rd_buf[0]), 32'h3C);

        // Reset part-way through a program's first data byte, CS held low across release.
        t_simple(OP_WREN);
        cs_low();
        xfer(OP_PP, 8'h00, 1'b0, 1'b0, d);
        send_addr(24'h000300);
        for (int i = 0; i < 4; i++) begin
            mosi = 1'($urandom);
            half();
            sck = 1'b1;
            half();
            sck = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        wel_m = 1'b0;
        err_m = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        xfer(OP_WREN, 8'h00, 1'b0, 1'b0, d);
        cs_high();
        gap();
        check("wren_ignored_cs_low", 32'(o_WEL), 32'd0);

        t_simple(8'h9F);
        check("err_bad_op", 32'(o_cmd_err), 32'd1);

        do_reset();
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a12 = 12'($urandom_range(0, 4095));
            else a12 = 12'h0F0 + 12'($urandom_range(0, 31));
            addr24 = {12'($urandom_range(0, 4095)), a12};
            case (kind)
                0, 1: t_simple(OP_WREN);
                2: t_simple(OP_WRDI);
                3: t_status(int'($urandom_range(1, 2)));
                4, 5, 6: t_read(addr24, int'($urandom_range(1, 4)));
                7, 8: begin
                    if ($urandom_range(0, 3) != 0) t_simple(OP_WREN);
                    for (int i = 0; i < 8; i++) wr_buf[i] = 8'($urandom);
                    t_prog(addr24, int'($urandom_range(0, 4)));
                end
                default: begin
                    do op = 8'($urandom_range(0, 255)); while (op >= 8'h02 && op <= 8'h06);
                    t_simple(op);
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
